cpu_control_fsm: RTL and testbench

- Multi-cycle control FSM for the 16-bit CR16-subset CPU, sitting directly upstream of the register file / ALU / PC datapath.
- Sequences fetch, decode, execute and writeback.
- Latches the instruction word into `ir` and decodes it into datapath controls: one-hot register write enables, ALU op, immediate, flag write, PC and memory controls.
- Datapath, memory and flag register are external. Benches observe `ir` and `reg_en` to check per-instruction results.

---
 rtl/cr16_pkg.sv | 99 +++++++++
 rtl/cond_eval.sv | 40 ++++
 rtl/cpu_control_fsm.sv | 186 ++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// Shared encodings for the CR16-subset core: FSM states, opcodes, ALU ops,
// PC select, condition codes and flag bit positions.
package cr16_pkg;

  localparam int unsigned CR16_DATA_W = 16;
  localparam int unsigned CR16_NREGS  = 16;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_LDWB
  } state_t;

  // Major opcodes, ir[15:12]; I-type opcodes reuse the R-type ext values
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_AND   = 4'b0001;
  localparam logic [3:0] EXT_OR    = 4'b0010;
  localparam logic [3:0] EXT_XOR   = 4'b0011;
  localparam logic [3:0] EXT_ADD   = 4'b0101;
  localparam logic [3:0] EXT_SUB   = 4'b1001;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_MOV   = 4'b1101;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_LSH   = 4'b0100;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_AND = 4'd1,
    ALU_OR  = 4'd2,
    ALU_XOR = 4'd3,
    ALU_ADD = 4'd4,
    ALU_SUB = 4'd5,
    ALU_CMP = 4'd6,
    ALU_MOV = 4'd7,
    ALU_LUI = 4'd8,
    ALU_LSH = 4'd9
  } alu_op_t;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_DISP = 2'b01;
  localparam logic [1:0] PC_REG  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_HS = 4'b1011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 4;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STOR,
    CL_BCOND,
    CL_JCOND,
    CL_ILL
  } iclass_t;

  typedef struct packed {
    iclass_t cls;
    alu_op_t op;
    logic    b_sel;
    logic    flag_en;
    logic    no_wb;
  } dec_t;

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator: cond code plus flag register to taken.
module cond_eval
  import cr16_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken_c
);

  logic c, l, f, z, n;

  assign c = flags[FLAG_C];
  assign l = flags[FLAG_L];
  assign f = flags[FLAG_F];
  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];

  always_comb begin
    taken_c = 1'b0;
    case (cond)
      COND_EQ: taken_c = z;
      COND_NE: taken_c = !z;
      COND_CS: taken_c = c;
      COND_CC: taken_c = !c;
      COND_HI: taken_c = l;
      COND_LS: taken_c = !l;
      COND_GT: taken_c = n;
      COND_LE: taken_c = !n;
      COND_FS: taken_c = f;
      COND_FC: taken_c = !f;
      COND_LO: taken_c = !l && !z;
      COND_HS: taken_c = l || z;
      COND_LT: taken_c = !n && !z;
      COND_GE: taken_c = n || z;
      COND_UC: taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/exec/writeback controller for the CR16-subset CPU.
// Controls are Moore decodes of state and ir, so reset silences them at once.
module cpu_control_fsm
  import cr16_pkg::*;
#(
  parameter int unsigned DATA_W = CR16_DATA_W,
  parameter int unsigned NREGS  = CR16_NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [4:0]        flags,
  output logic [DATA_W-1:0] ir,
  output logic              addr_sel,
  output logic              mem_we,
  output logic              pc_en,
  output logic [1:0]        pc_sel,
  output logic [3:0]        rdest,
  output logic [3:0]        rsrc,
  output logic [3:0]        alu_op,
  output logic              alu_b_sel,
  output logic [DATA_W-1:0] imm,
  output logic              flag_en,
  output logic              wb_sel,
  output logic [NREGS-1:0]  reg_en,
  output logic              illegal
);

  state_t            state, state_d;
  dec_t              dec;
  logic [DATA_W-1:0] dec_imm;
  logic [3:0]        opcode, ext;
  logic              taken;

  assign opcode = ir[15:12];
  assign ext    = ir[7:4];
  assign rdest  = ir[11:8];
  assign rsrc   = ir[3:0];

  cond_eval u_cond (
    .cond    (ir[11:8]),
    .flags   (flags),
    .taken_c (taken)
  );

  // State and instruction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= state_d;
      if (state == S_DECODE) ir <= mem_rdata;
    end
  end

  // Instruction decode: class, ALU op, operand select and immediate
  always_comb begin
    dec         = '{cls: CL_ILL, op: ALU_NOP, b_sel: 1'b0, flag_en: 1'b0, no_wb: 1'b0};
    dec_imm     = '0;
    case (opcode)
      OP_RTYPE: begin
        dec.cls = CL_ALU;
        case (ext)
          EXT_AND: dec.op = ALU_AND;
          EXT_OR:  dec.op = ALU_OR;
          EXT_XOR: dec.op = ALU_XOR;
          EXT_ADD: begin dec.op = ALU_ADD; dec.flag_en = 1'b1; end
          EXT_SUB: begin dec.op = ALU_SUB; dec.flag_en = 1'b1; end
          EXT_CMP: begin dec.op = ALU_CMP; dec.flag_en = 1'b1; dec.no_wb = 1'b1; end
          EXT_MOV: dec.op = ALU_MOV;
          default: dec.cls = CL_ILL;
        endcase
      end
      OP_ANDI: begin dec.cls = CL_ALU; dec.op = ALU_AND; dec.b_sel = 1'b1; dec_imm = DATA_W'(ir[7:0]); end
      OP_ORI:  begin dec.cls = CL_ALU; dec.op = ALU_OR;  dec.b_sel = 1'b1; dec_imm = DATA_W'(ir[7:0]); end
      OP_XORI: begin dec.cls = CL_ALU; dec.op = ALU_XOR; dec.b_sel = 1'b1; dec_imm = DATA_W'(ir[7:0]); end
      OP_MOVI: begin dec.cls = CL_ALU; dec.op = ALU_MOV; dec.b_sel = 1'b1; dec_imm = DATA_W'(ir[7:0]); end
      OP_ADDI: begin
        dec.cls = CL_ALU; dec.op = ALU_ADD; dec.b_sel = 1'b1; dec.flag_en = 1'b1;
        dec_imm = DATA_W'($signed(ir[7:0]));
      end
      OP_SUBI: begin
        dec.cls = CL_ALU; dec.op = ALU_SUB; dec.b_sel = 1'b1; dec.flag_en = 1'b1;
        dec_imm = DATA_W'($signed(ir[7:0]));
      end
      OP_CMPI: begin
        dec.cls = CL_ALU; dec.op = ALU_CMP; dec.b_sel = 1'b1; dec.flag_en = 1'b1;
        dec.no_wb = 1'b1;
        dec_imm = DATA_W'($signed(ir[7:0]));
      end
      OP_LUI: begin
        dec.cls = CL_ALU; dec.op = ALU_LUI; dec.b_sel = 1'b1;
        dec_imm = DATA_W'({ir[7:0], 8'h00});
      end
      OP_SHIFT: begin
        if (ext == EXT_LSH) begin
          dec.cls = CL_ALU; dec.op = ALU_LSH;
        end else if (ir[7:5] == 3'b000) begin
          dec.cls = CL_ALU; dec.op = ALU_LSH; dec.b_sel = 1'b1;
          dec_imm = DATA_W'($signed(ir[4:0]));
        end
      end
      OP_MEM: begin
        case (ext)
          EXT_LOAD:  dec.cls = CL_LOAD;
          EXT_STOR:  dec.cls = CL_STOR;
          EXT_JCOND: dec.cls = CL_JCOND;
          default:   dec.cls = CL_ILL;
        endcase
      end
      OP_BCOND: dec.cls = CL_BCOND;
      default:  dec.cls = CL_ILL;
    endcase
  end

  // Next state and Moore control outputs
  always_comb begin
    state_d   = state;
    addr_sel  = 1'b0;
    mem_we    = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = PC_INC;
    alu_op    = ALU_NOP;
    alu_b_sel = 1'b0;
    imm       = '0;
    flag_en   = 1'b0;
    wb_sel    = 1'b0;
    reg_en    = '0;
    illegal   = 1'b0;
    case (state)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (dec.cls)
          CL_ALU: begin
            alu_op    = dec.op;
            alu_b_sel = dec.b_sel;
            imm       = dec_imm;
            flag_en   = dec.flag_en;
            state_d   = S_WB;
          end
          CL_STOR: begin
            addr_sel = 1'b1;
            mem_we   = 1'b1;
            pc_en    = 1'b1;
          end
          CL_LOAD: begin
            addr_sel = 1'b1;
            state_d  = S_LDWB;
          end
          CL_BCOND: begin
            pc_en  = 1'b1;
            pc_sel = taken ? PC_DISP : PC_INC;
          end
          CL_JCOND: begin
            pc_en  = 1'b1;
            pc_sel = taken ? PC_REG : PC_INC;
          end
          default: begin
            illegal = 1'b1;
            pc_en   = 1'b1;
          end
        endcase
      end
      S_WB: begin
        // ALU operands stay presented so the result is still valid at the write
        alu_op    = dec.op;
        alu_b_sel = dec.b_sel;
        imm       = dec_imm;
        reg_en    = dec.no_wb ? '0 : (NREGS'(1) << rdest);
        pc_en     = 1'b1;
        state_d   = S_FETCH;
      end
      S_LDWB: begin
        reg_en  = NREGS'(1) << rdest;
        wb_sel  = 1'b1;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: stimulus queues per-cycle expected
// controls, a negedge monitor pops and compares them against the DUT.
module tb_cpu_control_fsm;
  import cr16_pkg::*;

  localparam int K_ALU  = 0;
  localparam int K_LOAD = 1;
  localparam int K_STOR = 2;
  localparam int K_BR   = 3;
  localparam int K_ILL  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_rdata;
  logic [4:0]  flags;
  logic [15:0] ir;
  logic        addr_sel, mem_we, pc_en, alu_b_sel, flag_en, wb_sel, illegal;
  logic [1:0]  pc_sel;
  logic [3:0]  rdest, rsrc, alu_op;
  logic [15:0] imm;
  logic [15:0] reg_en;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic        addr_sel, mem_we, pc_en;
    logic [1:0]  pc_sel;
    logic [3:0]  alu_op;
    logic        alu_b_sel;
    logic [15:0] imm;
    logic        flag_en, wb_sel;
    logic [15:0] reg_en;
    logic        illegal;
    bit          chk_addr, chk_pcsel, chk_alu, chk_imm, chk_wb;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_ir = 16'h0000;

  cpu_control_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rdata (mem_rdata),
    .flags     (flags),
    .ir        (ir),
    .addr_sel  (addr_sel),
    .mem_we    (mem_we),
    .pc_en     (pc_en),
    .pc_sel    (pc_sel),
    .rdest     (rdest),
    .rsrc      (rsrc),
    .alu_op    (alu_op),
    .alu_b_sel (alu_b_sel),
    .imm       (imm),
    .flag_en   (flag_en),
    .wb_sel    (wb_sel),
    .reg_en    (reg_en),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask

  // Monitor: one expected record per cycle, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.name, ".ir"},      ir,                  e.ir);
      chk({e.name, ".rdest"},   16'(rdest),          16'(e.ir[11:8]));
      chk({e.name, ".rsrc"},    16'(rsrc),           16'(e.ir[3:0]));
      chk({e.name, ".mem_we"},  16'(mem_we),         16'(e.mem_we));
      chk({e.name, ".pc_en"},   16'(pc_en),          16'(e.pc_en));
      chk({e.name, ".flag_en"}, 16'(flag_en),        16'(e.flag_en));
      chk({e.name, ".reg_en"},  reg_en,              e.reg_en);
      chk({e.name, ".illegal"}, 16'(illegal),        16'(e.illegal));
      if (e.chk_addr)  chk({e.name, ".addr_sel"},  16'(addr_sel),  16'(e.addr_sel));
      if (e.chk_pcsel) chk({e.name, ".pc_sel"},    16'(pc_sel),    16'(e.pc_sel));
      if (e.chk_alu)   chk({e.name, ".alu_op"},    16'(alu_op),    16'(e.alu_op));
      if (e.chk_alu)   chk({e.name, ".alu_b_sel"}, 16'(alu_b_sel), 16'(e.alu_b_sel));
      if (e.chk_imm)   chk({e.name, ".imm"},       imm,            e.imm);
      if (e.chk_wb)    chk({e.name, ".wb_sel"},    16'(wb_sel),    16'(e.wb_sel));
    end
  end

  function automatic exp_t blank(input logic [15:0] irv, input string n);
    exp_t e;
    e.name = n;       e.ir = irv;
    e.addr_sel = 1'b0; e.mem_we = 1'b0; e.pc_en = 1'b0; e.pc_sel = 2'b00;
    e.alu_op = 4'h0;  e.alu_b_sel = 1'b0; e.imm = 16'h0000;
    e.flag_en = 1'b0; e.wb_sel = 1'b0; e.reg_en = 16'h0000; e.illegal = 1'b0;
    e.chk_addr = 1'b0; e.chk_pcsel = 1'b0; e.chk_alu = 1'b0;
    e.chk_imm = 1'b0; e.chk_wb = 1'b0;
    return e;
  endfunction

  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string n, input logic [15:0] instr, input logic [4:0] flg,
                     input int kind, input logic [3:0] op, input logic bsel,
                     input logic [15:0] im, input bit chk_im, input logic fen,
                     input logic [15:0] ren, input logic [1:0] psel);
    exp_t e;
    mem_rdata = instr;
    flags     = flg;
    e = blank(last_ir, {n, ".fetch"});
    e.chk_addr = 1'b1;
    step(e);
    e = blank(last_ir, {n, ".decode"});
    step(e);
    last_ir = instr;
    e = blank(instr, {n, ".exec"});
    case (kind)
      K_ALU: begin
        e.chk_alu = 1'b1; e.alu_op = op; e.alu_b_sel = bsel;
        e.chk_imm = chk_im; e.imm = im; e.flag_en = fen;
      end
      K_LOAD: begin e.chk_addr = 1'b1; e.addr_sel = 1'b1; end
      K_STOR: begin
        e.chk_addr = 1'b1; e.addr_sel = 1'b1; e.mem_we = 1'b1;
        e.pc_en = 1'b1; e.chk_pcsel = 1'b1; e.pc_sel = 2'b00;
      end
      K_BR: begin e.pc_en = 1'b1; e.chk_pcsel = 1'b1; e.pc_sel = psel; end
      default: begin
        e.illegal = 1'b1; e.pc_en = 1'b1; e.chk_pcsel = 1'b1; e.pc_sel = 2'b00;
      end
    endcase
    step(e);
    if (kind == K_ALU) begin
      e = blank(instr, {n, ".wb"});
      e.reg_en = ren; e.chk_wb = 1'b1; e.wb_sel = 1'b0;
      e.pc_en = 1'b1; e.chk_pcsel = 1'b1; e.pc_sel = 2'b00;
      step(e);
    end else if (kind == K_LOAD) begin
      e = blank(instr, {n, ".ldwb"});
      e.reg_en = ren; e.chk_wb = 1'b1; e.wb_sel = 1'b1; e.pc_en = 1'b1;
      step(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    mem_rdata = 16'h0000;
    flags = 5'b00000;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = blank(16'h0000, "reset");
      e.chk_addr = 1'b1;
      step(e);
    end
    rst = 1'b0;

    //  name       instr      flags     kind    alu_op   bsel imm       chkimm fen reg_en     pc_sel
    run("add",     16'h0351, 5'b00000, K_ALU,  ALU_ADD, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 2'b00);
    run("cmpi",    16'hBF85, 5'b00000, K_ALU,  ALU_CMP, 1'b1, 16'hFF85, 1'b1, 1'b1, 16'h0000, 2'b00);
    run("andi",    16'h1A80, 5'b00000, K_ALU,  ALU_AND, 1'b1, 16'h0080, 1'b1, 1'b0, 16'h0400, 2'b00);
    run("addi",    16'h51F0, 5'b00000, K_ALU,  ALU_ADD, 1'b1, 16'hFFF0, 1'b1, 1'b1, 16'h0002, 2'b00);
    run("lui",     16'hF712, 5'b00000, K_ALU,  ALU_LUI, 1'b1, 16'h1200, 1'b1, 1'b0, 16'h0080, 2'b00);
    run("lshi",    16'h821D, 5'b00000, K_ALU,  ALU_LSH, 1'b1, 16'hFFFD, 1'b1, 1'b0, 16'h0004, 2'b00);
    run("lsh",     16'h8142, 5'b00000, K_ALU,  ALU_LSH, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0002, 2'b00);
    run("movi",    16'hD4FF, 5'b00000, K_ALU,  ALU_MOV, 1'b1, 16'h00FF, 1'b1, 1'b0, 16'h0010, 2'b00);
    run("sub",     16'h0092, 5'b00000, K_ALU,  ALU_SUB, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 2'b00);
    run("load",    16'h4204, 5'b00000, K_LOAD, ALU_NOP, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 2'b00);
    run("stor",    16'h4744, 5'b00000, K_STOR, ALU_NOP, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00);
    run("beq_t",   16'hC0FE, 5'b01000, K_BR,   ALU_NOP, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b01);
    run("beq_n",   16'hC0FE, 5'b00000, K_BR,   ALU_NOP, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00);
    run("bne_n",   16'hC1FE, 5'b01000, K_BR,   ALU_NOP, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00);
    run("blo_t",   16'hCAFE, 5'b00000, K_BR,   ALU_NOP, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b01);
    run("bnever",  16'hCFFE, 5'b11111, K_BR,   ALU_NOP, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00);
    run("juc",     16'h4EC5, 5'b00000, K_BR,   ALU_NOP, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b10);
    run("illegal", 16'h7000, 5'b00000, K_ILL,  ALU_NOP, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00);

    // Reset asserted at the start of a STOR's EXEC cycle: no write may happen
    mem_rdata = 16'h4744;
    e = blank(last_ir, "rst_mid.fetch");
    step(e);
    e = blank(last_ir, "rst_mid.decode");
    step(e);
    rst = 1'b1;
    e = blank(16'h0000, "rst_mid.exec");
    e.chk_addr = 1'b1;
    step(e);
    e = blank(16'h0000, "rst_mid.hold");
    step(e);
    rst = 1'b0;
    last_ir = 16'h0000;
    run("add_after_rst", 16'h0351, 5'b00000, K_ALU, ALU_ADD, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 2'b00);

    @(negedge clk);
    #1;
    chk("queue_drain", 16'(q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
